// File: rtl/bch_codeword_serializer_if.sv
// Stream bundle for the BCH codeword serializer: a parallel word-in handshake
// and a serial bit-out handshake with frame markers and a completed-frame count.
interface bch_codeword_serializer_if #(
    parameter int P_D_WIDTH = 21,
    parameter int P_P_WIDTH = 10
);
    logic [P_D_WIDTH-1:0] data_i;
    logic [P_P_WIDTH-1:0] ecc_i;
    logic                 in_valid;
    logic                 in_ready;
    logic                 bit_o;
    logic                 bit_valid;
    logic                 bit_ready;
    logic                 sof_o;
    logic                 eof_o;
    logic [15:0]          frame_cnt;

    modport master (
        output data_i, ecc_i, in_valid, bit_ready,
        input  in_ready, bit_o, bit_valid, sof_o, eof_o, frame_cnt
    );

    modport slave (
        input  data_i, ecc_i, in_valid, bit_ready,
        output in_ready, bit_o, bit_valid, sof_o, eof_o, frame_cnt
    );
endinterface

// File: rtl/bch_codeword_serializer.sv
// Serializes systematic BCH codewords {data, parity} MSB first through a
// one-entry holding register and a shift register, back-to-back when possible.
module bch_codeword_serializer #(
    parameter int P_D_WIDTH = 21,
    parameter int P_P_WIDTH = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    bch_codeword_serializer_if.slave        bus
);
    localparam int N  = P_D_WIDTH + P_P_WIDTH;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [N-1:0]    r_hold;
    logic            r_hold_full;
    logic [N-1:0]    r_shift;
    logic [CW-1:0]   r_cnt;
    logic [15:0]     r_frame_cnt;
    logic            w_in_xfer;
    logic            w_bit_xfer;
    logic            w_eof_xfer;
    logic            w_load;

    // in_ready depends only on the holding flag, never on bit_ready
    assign w_in_xfer = bus.in_valid && !r_hold_full;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_bit_xfer   = 1'b0;
        w_eof_xfer   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_hold_full) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                w_bit_xfer = bus.bit_ready;
                w_eof_xfer = bus.bit_ready && (r_cnt == LAST);
                if (w_eof_xfer) begin
                    w_load       = r_hold_full;
                    w_state_next = r_hold_full ? ST_SEND : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A new word landing on the same edge as a load wins, leaving holding full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_load) begin
                r_hold_full <= 1'b0;
            end
            if (w_in_xfer) begin
                r_hold      <= {bus.data_i, bus.ecc_i};
                r_hold_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_shift <= r_hold;
            r_cnt   <= '0;
        end else if (w_eof_xfer) begin
            r_shift <= r_shift << 1;
            r_cnt   <= '0;
        end else if (w_bit_xfer) begin
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_eof_xfer) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign bus.in_ready  = !r_hold_full;
    assign bus.bit_valid = (r_state == ST_SEND);
    assign bus.bit_o     = (r_state == ST_SEND) && r_shift[N-1];
    assign bus.sof_o     = (r_state == ST_SEND) && (r_cnt == '0);
    assign bus.eof_o     = (r_state == ST_SEND) && (r_cnt == LAST);
    assign bus.frame_cnt = r_frame_cnt;
endmodule
